// File: rtl/debounce_new_data_unit_pkg.sv
// Shared definitions for the debounce / new-data pulse unit.
package debounce_new_data_unit_pkg;

    // Two-state press detector: waiting for a press, or waiting for quiet.
    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DEFAULT_SYNC_STAGES    = 2;
    localparam int DEFAULT_LOCKOUT_CYCLES = 8;

endpackage

// File: rtl/debounce_new_data_unit_sync.sv
// Parameterized N-flop synchronizer with asynchronous active-low clear.
// Reusable for any pin-facing single-bit input.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_p0;

    // Shift the raw input through the flop chain; the first flop absorbs metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_p0 <= '0;
        end else begin
            chain_p0 <= {chain_p0[STAGES-2:0], d};
        end
    end

    assign q = chain_p0[STAGES-1];

endmodule

// File: rtl/debounce_new_data_unit.sv
// Input conditioner: synchronizes a bouncing line and emits one single-cycle
// pulse per press, then ignores the line until it has been low for
// LOCKOUT_CYCLES consecutive synchronized samples.
module debounce_new_data_unit
    import debounce_new_data_unit_pkg::*;
#(
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int LOCKOUT_CYCLES = DEFAULT_LOCKOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int               CNT_W    = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              s;
    state_t            state;
    logic [CNT_W-1:0]  count;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in),
        .q     (s)
    );

    // Press detector: pulse on the first high sample while armed, then hold
    // off until the quiet window has fully elapsed. Any high sample while
    // locked restarts the window, so a bounce burst yields a single pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARMED;
            count <= '0;
            out   <= 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (s) begin
                        out   <= 1'b1;
                        count <= CNT_LOAD;
                        state <= LOCKED;
                    end else begin
                        out   <= 1'b0;
                    end
                end
                LOCKED: begin
                    out <= 1'b0;
                    if (s) begin
                        count <= CNT_LOAD;
                    end else if (count <= CNT_ONE) begin
                        // Counter saturates at zero; reaching it re-arms on this edge.
                        count <= '0;
                        state <= ARMED;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    out   <= 1'b0;
                    count <= '0;
                    state <= ARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_new_data_unit.sv
// Directed bench for debounce_new_data_unit with a pulse scoreboard.
module tb_debounce_new_data_unit;

    logic clk;
    logic reset;
    logic in_line;
    logic out_line;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;   // free-running count of rising edges
    int base   = 0;   // edge count at the latest reset release (cycle n = edge base+n)
    int exp_q[$];     // expected pulse edges

    debounce_new_data_unit dut (
        .clk   (clk),
        .reset (reset),
        .in    (in_line),
        .out   (out_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            total++;
            if (out_line !== 1'b0) begin
                bad++;
                $display("FAIL reset_out edge=%0d actual=%b required=0", edge_n, out_line);
            end
        end else if (out_line === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse actual_edge=%0d required=none", edge_n);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e != edge_n) begin
                    bad++;
                    $display("FAIL pulse_edge actual=%0d required=%0d", edge_n, e);
                end
            end
        end else if (out_line !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL out_unknown edge=%0d actual=%b required=0/1", edge_n, out_line);
        end else if (exp_q.size() > 0 && exp_q[0] < edge_n) begin
            total++;
            bad++;
            $display("FAIL missed_pulse actual=none required_edge=%0d", exp_q[0]);
            void'(exp_q.pop_front());
        end
    end

    // Wait for the falling edge just before cycle c, so a value driven now is sampled at cycle c.
    task automatic wait_cycle(input int c);
        while (edge_n < base + c - 1) @(negedge clk);
    endtask

    task automatic drive(input logic v, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            wait_cycle(c);
            in_line = v;
        end
    endtask

    task automatic expect_pulse(input int c);
        exp_q.push_back(base + c);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        base  = edge_n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        in_line = 1'b0;

        // Reset hold with the input toggling.
        repeat (3) begin
            @(negedge clk);
            in_line = ~in_line;
        end
        @(negedge clk);
        in_line = 1'b0;
        release_reset();

        // Bounce burst: one pulse at cycle 6.
        expect_pulse(6);
        drive(1'b1, 4, 5);
        drive(1'b0, 6, 7);
        drive(1'b1, 8, 8);
        drive(1'b0, 9, 18);

        // Re-arm and second burst: one pulse at cycle 21.
        expect_pulse(21);
        drive(1'b1, 19, 20);
        drive(1'b0, 21, 21);
        drive(1'b1, 22, 22);
        drive(1'b0, 23, 39);

        // Early retrigger after 5 low cycles: no pulse; later press pulses.
        expect_pulse(42);
        drive(1'b1, 40, 40);
        drive(1'b0, 41, 45);
        drive(1'b1, 46, 46);
        drive(1'b0, 47, 59);
        expect_pulse(62);
        drive(1'b1, 60, 60);
        drive(1'b0, 61, 79);

        // Held high for 50 cycles: single pulse 2 cycles after first high sample.
        expect_pulse(82);
        drive(1'b1, 80, 129);
        drive(1'b0, 130, 149);

        // Reset mid-lockout, then an immediate press with no lockout wait.
        expect_pulse(152);
        drive(1'b1, 150, 150);
        drive(1'b0, 151, 154);
        wait_cycle(155);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        in_line = 1'b1;
        reset   = 1'b1;
        base    = edge_n;
        expect_pulse(3);
        drive(1'b0, 2, 19);

        // Reset asserted during a pulse clears the output at once.
        drive(1'b1, 20, 20);
        drive(1'b0, 21, 21);
        do begin
            @(posedge clk);
            #1;
        end while (edge_n < base + 22);
        total++;
        if (out_line !== 1'b1) begin
            bad++;
            $display("FAIL pulse_before_async_reset actual=%b required=1", out_line);
        end
        reset = 1'b0;
        #1;
        total++;
        if (out_line !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_clear actual=%b required=0", out_line);
        end
        repeat (2) @(negedge clk);
        release_reset();
        drive(1'b0, 1, 20);
        wait_cycle(21);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_pulses actual=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
